// File: rtl/ntt_pkg.sv
// Shared constants and modular add/sub/halve helpers for the p = 65537 NTT datapath.
package ntt_pkg;

  localparam int PRIME = 65537;
  localparam int M     = 16;
  localparam int WIDTH = 18;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] s;
    s = a + r;
    if (s >= WIDTH'(PRIME)) s = s - WIDTH'(PRIME);
    return s;
  endfunction

  // Top bit of the WIDTH-bit difference acts as the sign for residues below 2^17.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] d;
    d = a - r;
    if (d[WIDTH-1]) d = d + WIDTH'(PRIME);
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] h;
    if (v[0]) h = (v + WIDTH'(PRIME)) >> 1;
    else      h = v >> 1;
    return h;
  endfunction

endpackage

// File: rtl/ntt_butterfly_reduce.sv
// Fermat reduction of a double-width product modulo 2^M + 1.
// Latency: combinational.
// Backpressure: none; pure function of prod.
module ntt_butterfly_reduce #(
  parameter int WIDTH = 18,
  parameter int PRIME = 65537
) (
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   r
);
  import ntt_pkg::*;

  logic [WIDTH-1:0] lo, mid, hi, t;

  // 2^M == -1 and 2^(2M) == +1, so prod == lo - mid + hi (mod p).
  always_comb begin
    lo  = WIDTH'(prod[M-1:0]);
    mid = WIDTH'(prod[2*M-1:M]);
    hi  = WIDTH'(prod[2*WIDTH-1:2*M]);
    t   = lo - mid + hi;
    if (t[WIDTH-1])                r = t + WIDTH'(PRIME);
    else if (t >= WIDTH'(PRIME))   r = t - WIDTH'(PRIME);
    else                           r = t;
  end

endmodule

// File: rtl/ntt_butterfly.sv
// Cooley-Tukey butterfly X=(a+w*b) mod p, Y=(a-w*b) mod p; NTT_BFLY_HALVE_EN adds half_in scaling.
// Latency: 3 cycles, 1 op/cycle.
// Backpressure: global stall when out_valid & ~out_ready; every stage holds, in_ready low.
module ntt_butterfly #(
  parameter int WIDTH = 18,
  parameter int TAG_W = 10,
  parameter int PRIME = 65537
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] w_in,
  input  logic [TAG_W-1:0] tag_in,
`ifdef NTT_BFLY_HALVE_EN
  input  logic             half_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [TAG_W-1:0] tag_out
);
  import ntt_pkg::*;

  logic               en;
  logic               s1_vld, s2_vld;
  logic [WIDTH-1:0]   s1_a, s2_a, s2_r, red_r, x_c, y_c;
  logic [TAG_W-1:0]   s1_tag, s2_tag;
  logic [2*WIDTH-1:0] s1_prod;

  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  ntt_butterfly_reduce #(.WIDTH(WIDTH), .PRIME(PRIME)) u_reduce (
    .prod (s1_prod),
    .r    (red_r)
  );

`ifdef NTT_BFLY_HALVE_EN
  logic s1_half, s2_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_half <= 1'b0;
      s2_half <= 1'b0;
    end else if (en) begin
      s1_half <= half_in;
      s2_half <= s1_half;
    end
  end
`endif

  always_comb begin
    x_c = add_mod(s2_a, s2_r);
    y_c = sub_mod(s2_a, s2_r);
`ifdef NTT_BFLY_HALVE_EN
    if (s2_half) begin
      x_c = halve_mod(x_c);
      y_c = halve_mod(y_c);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_a      <= '0;
      s1_tag    <= '0;
      s1_prod   <= '0;
      s2_vld    <= 1'b0;
      s2_a      <= '0;
      s2_tag    <= '0;
      s2_r      <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      tag_out   <= '0;
    end else if (en) begin
      s1_vld    <= in_valid;
      s1_a      <= a_in;
      s1_tag    <= tag_in;
      s1_prod   <= (2*WIDTH)'(w_in) * (2*WIDTH)'(b_in);
      s2_vld    <= s1_vld;
      s2_a      <= s1_a;
      s2_tag    <= s1_tag;
      s2_r      <= red_r;
      out_valid <= s2_vld;
      x_out     <= x_c;
      y_out     <= y_c;
      tag_out   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Directed and randomised checks of ntt_butterfly against an integer reference model.
module tb_ntt_butterfly;

  localparam longint P = 65537;

  typedef struct packed {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] w;
    logic [9:0]  tag;
    logic        half;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [17:0] a_in, b_in, w_in, x_out, y_out;
  logic [9:0]  tag_in, tag_out;
`ifdef NTT_BFLY_HALVE_EN
  logic        half_in;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  logic [17:0] exp_x[$], exp_y[$];
  logic [9:0]  exp_t[$];
  bit          prev_stall = 1'b0;
  logic [17:0] px, py;
  logic [9:0]  pt;

  always #5 clk = ~clk;

  ntt_butterfly #(.WIDTH(18), .TAG_W(10), .PRIME(65537)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .w_in      (w_in),
    .tag_in    (tag_in),
`ifdef NTT_BFLY_HALVE_EN
    .half_in   (half_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .tag_out   (tag_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ref_half(input longint v, input logic half);
    if (!half) return 18'(v);
    if (v % 2 == 1) return 18'((v + P) / 2);
    return 18'(v / 2);
  endfunction

  task automatic push_model(input op_t op);
    longint r, x, y;
    r = (longint'(op.w) * longint'(op.b)) % P;
    x = (longint'(op.a) + r) % P;
    y = (longint'(op.a) + P - r) % P;
`ifdef NTT_BFLY_HALVE_EN
    exp_x.push_back(ref_half(x, op.half));
    exp_y.push_back(ref_half(y, op.half));
`else
    exp_x.push_back(ref_half(x, 1'b0));
    exp_y.push_back(ref_half(y, 1'b0));
`endif
    exp_t.push_back(op.tag);
  endtask

  task automatic drive(input logic iv, input op_t op);
    in_valid = iv;
    a_in     = op.a;
    b_in     = op.b;
    w_in     = op.w;
    tag_in   = op.tag;
`ifdef NTT_BFLY_HALVE_EN
    half_in  = op.half;
`endif
  endtask

  // Called at a falling edge; ends at the next falling edge.
  task automatic run_cycle(input logic iv, input op_t op, input logic ordy, output logic acc);
    drive(iv, op);
    out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("hold_vld", out_valid, 1);
      chk("hold_x", x_out, px);
      chk("hold_y", y_out, py);
      chk("hold_tag", tag_out, pt);
    end
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      if (exp_x.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        chk("x_out", x_out, exp_x.pop_front());
        chk("y_out", y_out, exp_y.pop_front());
        chk("tag_out", tag_out, exp_t.pop_front());
        n_out++;
      end
    end
    acc = iv && in_ready;
    if (acc) push_model(op);
    prev_stall = out_valid && !out_ready;
    px = x_out;
    py = y_out;
    pt = tag_out;
    @(negedge clk);
  endtask

  task automatic single_op(input op_t op, input logic [17:0] ex, input logic [17:0] ey);
    drive(1'b1, op);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat1_vld", out_valid, 0);
    @(negedge clk);
    chk("lat2_vld", out_valid, 0);
    @(negedge clk);
    chk("lat3_vld", out_valid, 1);
    chk("single_x", x_out, ex);
    chk("single_y", y_out, ey);
    chk("single_tag", tag_out, op.tag);
    @(negedge clk);
    chk("drain_vld", out_valid, 0);
  endtask

  function automatic logic [17:0] rnd_res();
    case ($urandom_range(0, 7))
      0:       return 18'd65536;
      1:       return 18'd0;
      2:       return 18'd1;
      default: return 18'($urandom_range(0, 65536));
    endcase
  endfunction

  function automatic op_t rnd_op(input int idx);
    op_t o;
    o.a    = rnd_res();
    o.b    = rnd_res();
    o.w    = rnd_res();
    o.tag  = 10'(idx);
    o.half = 1'($urandom_range(0, 1));
    return o;
  endfunction

  initial begin
    op_t  op;
    logic acc;
    int   issued;
    int   cyc;

    rst_n = 1'b0;
    op = '0;
    drive(1'b0, op);
    out_ready = 1'b1;
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_tag", tag_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Directed vectors, no stall
    single_op('{a: 18'd5, b: 18'd3, w: 18'd2, tag: 10'h15, half: 1'b0}, 18'd11, 18'd65536);
    single_op('{a: 18'd0, b: 18'd65536, w: 18'd65536, tag: 10'h2a, half: 1'b0}, 18'd1, 18'd65536);
    single_op('{a: 18'd65536, b: 18'd1, w: 18'd1, tag: 10'h3ff, half: 1'b0}, 18'd0, 18'd65535);
    single_op('{a: 18'd0, b: 18'd3, w: 18'd2, tag: 10'h001, half: 1'b0}, 18'd6, 18'd65531);
    single_op('{a: 18'd100, b: 18'd65536, w: 18'd2, tag: 10'h0c3, half: 1'b0}, 18'd98, 18'd102);
`ifdef NTT_BFLY_HALVE_EN
    single_op('{a: 18'd1, b: 18'd0, w: 18'd7, tag: 10'h055, half: 1'b1}, 18'd32769, 18'd32769);
    single_op('{a: 18'd1, b: 18'd0, w: 18'd7, tag: 10'h056, half: 1'b0}, 18'd1, 18'd1);
    single_op('{a: 18'd5, b: 18'd3, w: 18'd2, tag: 10'h057, half: 1'b1}, 18'd32774, 18'd32768);
`endif

    // 8 back-to-back ops with out_ready low on cycles 4..6
    issued = 0;
    n_out  = 0;
    for (int c = 1; c <= 40 && (issued < 8 || exp_x.size() != 0); c++) begin
      op = '{a: 18'(1000 * issued + 7), b: 18'(65536 - issued), w: 18'(3 + issued),
             tag: 10'(16'h100 + issued), half: 1'b0};
      run_cycle(issued < 8, op, !(c >= 4 && c <= 6), acc);
      if (c >= 5 && c <= 6) chk("stall_in_ready", in_ready, 0);
      if (acc) issued++;
    end
    chk("stall_issued", issued, 8);
    chk("stall_emitted", n_out, 8);
    chk("stall_left", exp_x.size(), 0);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      op = '{a: 18'(i + 1), b: 18'(i + 2), w: 18'(i + 3), tag: 10'(16'h200 + i), half: 1'b0};
      run_cycle(1'b1, op, 1'b1, acc);
    end
    drive(1'b0, op);
    chk("pre_rst_vld", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_x", x_out, 0);
    chk("mid_rst_y", y_out, 0);
    chk("mid_rst_tag", tag_out, 0);
    exp_x.delete();
    exp_y.delete();
    exp_t.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, op, 1'b1, acc);
      chk("post_rst_vld", out_valid, 0);
    end

    // Random traffic with random backpressure
    issued = 0;
    n_out  = 0;
    op     = rnd_op(0);
    cyc    = 0;
    while (issued < 10000 && cyc < 40000) begin
      run_cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 3) != 0, acc);
      if (acc) begin
        issued++;
        op = rnd_op(issued);
      end
      cyc++;
    end
    for (int i = 0; i < 50 && exp_x.size() != 0; i++) run_cycle(1'b0, op, 1'b1, acc);
    chk("rand_issued", issued, 10000);
    chk("rand_emitted", n_out, issued);
    chk("rand_left", exp_x.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly.md
Name: ntt_butterfly

Overview:
Pipelined Cooley-Tukey NTT butterfly over the Fermat prime p = 65537.
- Computes X = (a + w·b) mod p and Y = (a − w·b) mod p.
- Sits directly upstream of the modular reduction stage: forms the double-width product w·b, reduces it through the existing reduction block, then does the add/sub with correction.
- Fed by the NTT address/twiddle controller; outputs go to the coefficient RAM write-back.

Parameters:
- WIDTH, 18: residue word width. Residues are in 0..65536 (17 significant bits).
- TAG_W, 10: width of the opaque tag (write-back address) carried alongside each operation.
- PRIME, 65537: modulus. Fixed; must equal the reduction block's prime.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input operation valid.
- in_ready, output, 1: block can accept an operation this cycle.
- a_in, input, WIDTH: operand a, 0..p−1.
- b_in, input, WIDTH: operand b, 0..p−1.
- w_in, input, WIDTH: twiddle factor, 0..p−1.
- tag_in, input, TAG_W: opaque tag.
- out_valid, output, 1: results valid.
- out_ready, input, 1: consumer accepts results.
- x_out, output, WIDTH: (a + w·b) mod p.
- y_out, output, WIDTH: (a − w·b) mod p.
- tag_out, output, TAG_W: tag of the result on x_out/y_out.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, out_valid = 0, x_out = y_out = 0, tag_out = 0. in_ready = 1 one cycle after deassertion.
- Three register stages: S1, S2, S3. S3 drives the outputs.
  - S1: registers a, tag, and prod = w·b (2·WIDTH bits, unsigned, max 2^32).
  - S2: registers a, tag, and r = reduce(prod), 0..p−1.
  - S3: registers x = (a + r) mod p and y = (a − r) mod p.
- Add/sub correction:
  - x: compute a + r in WIDTH bits; subtract p if ≥ p.
  - y: compute a − r in WIDTH bits; add p if negative (bit WIDTH−1 set).
- Latency: 3 cycles from input accept to out_valid with no stall. Throughput 1 op/cycle.
- Handshake:
  - Transfer occurs when valid & ready are both high on a clock edge.
  - stall = out_valid & ~out_ready. When stall is set, all stages hold.
  - in_ready = ~stall (combinational).
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - No bubbles are collapsed: a simple global-enable pipeline.
- Stage valid bits advance on every non-stalled edge; bubbles propagate as valid=0.
- Operands ≥ p: result undefined; no check.
- Boundary cases:
  - w = b = 65536 (≡ −1): prod = 2^32, r = 1.
  - a = 0, r > 0: y = p − r.
  - a + r = p: x = 0.
- Reset mid-operation: in-flight ops are discarded; nothing is emitted after release until new inputs arrive.

Optional Feature:
- Macro NTT_BFLY_HALVE_EN.
- Defined:
  - Adds input port half_in (1 bit), carried through the pipeline with its operation.
  - When half=1, S3 outputs x/2 mod p and y/2 mod p: v even → v>>1; v odd → (v+p)>>1.
  - Used for INTT scaling.
  - Latency unchanged; halving is folded into S3 after the correction.
- Undefined: no half_in port; plain butterfly.

Decomposition:
- Shared package ntt_pkg holds:
  - PRIME = 65537, M = 16, WIDTH = 18.
  - helper functions add_mod and sub_mod.
- One sub-module: the existing modulo reduction block, instantiated in S2 with WIDTH=18.
- No other sub-modules.

Test Plan:
- a=5, b=3, w=2, no stall → after 3 cycles x_out=11, y_out=65536, tag echoed.
- a=0, b=65536, w=65536 → x_out=1, y_out=65536. a=65536, b=1, w=1 → x_out=0, y_out=65535.
- 8 back-to-back ops with out_ready=0 on cycles 4–6:
  - in_ready low during the stall;
  - outputs held stable;
  - all 8 results emerge in order with correct tags; none lost or duplicated.
- Assert rst_n low with 3 ops in flight:
  - out_valid drops asynchronously, outputs = 0;
  - no stale output appears after release.
- Random 10k ops vs. reference model (a ± w·b mod p), random out_ready → full match.
- NTT_BFLY_HALVE_EN defined: a=1, b=0, w=7, half=1 → x_out=y_out=32769; with half=0 → x_out=y_out=1.
